// File: rtl/uart_rx_pkg.sv
// Shared types and limits for the UART receive core: FSM states, parity encoding,
// and the floor values that out-of-range configuration inputs are clamped to.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_typ_e;

    localparam int MIN_PRESCALE = 8;
    localparam int MIN_DATA_LEN = 5;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point mid-bit capture of RX_IN with 2-of-3 majority vote.
// Captures at P/2-1, P/2, P/2+1; the vote is registered at P/2+2 and held until the next bit.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] p,
    input  logic                  rx_in,
    output logic                  bit_val
);

    logic [PRESCALE_W-1:0] half;
    logic [2:0]            smp_q, smp_d;
    logic                  bit_q, bit_d;

    assign half    = p >> 1;
    assign bit_val = bit_q;

    always_comb begin
        smp_d = smp_q;
        bit_d = bit_q;
        if (edge_cnt == half - PRESCALE_W'(1)) smp_d[0] = rx_in;
        if (edge_cnt == half)                  smp_d[1] = rx_in;
        if (edge_cnt == half + PRESCALE_W'(1)) smp_d[2] = rx_in;
        if (edge_cnt == half + PRESCALE_W'(2))
            bit_d = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            smp_q <= '0;
            bit_q <= 1'b0;
        end else begin
            smp_q <= smp_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive core: frame FSM, counters, deserializer, parity/stop checks; optional break detect (UART_RX_BREAK_DET_EN).
// Result outputs are decoded from registered state so they show during edge P-1 of the last stop bit; no backpressure.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6,
    parameter int LEN_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic [LEN_W-1:0]      DATA_LEN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  STRT_GLITCH,
`ifdef UART_RX_BREAK_DET_EN
    output logic                  BRK_DET,
`endif
    output logic                  BUSY
);

    localparam int BCNT_W = LEN_W + 1;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d, p_q, p_d, p_cfg;
    logic [BCNT_W-1:0]     bitc_q, bitc_d;
    logic [LEN_W-1:0]      len_q, len_d, len_cfg;
    logic                  par_en_q, par_en_d, stop2_q, stop2_d;
    par_typ_e              par_typ_q, par_typ_d;
    logic [DATA_W-1:0]     shreg_q, shreg_d, p_data_q, p_data_d;
    logic                  par_flag_q, par_flag_d, stp_flag_q, stp_flag_d;
    logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                  bit_val, bit_end, stop_last, complete, stp_now, frame_ok;
    logic                  start_frame, glitch;
`ifdef UART_RX_BREAK_DET_EN
    logic                  brk_cand_q, brk_cand_d, first_stop, brk_hit;
`endif

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .edge_cnt (edge_q),
        .p        (p_q),
        .rx_in    (RX_IN),
        .bit_val  (bit_val)
    );

    always_comb begin
        p_cfg = PRESCALE & ~PRESCALE_W'(1);
        if (p_cfg < PRESCALE_W'(MIN_PRESCALE)) p_cfg = PRESCALE_W'(MIN_PRESCALE);
        len_cfg = DATA_LEN;
        if (DATA_LEN < LEN_W'(MIN_DATA_LEN))  len_cfg = LEN_W'(MIN_DATA_LEN);
        else if (DATA_LEN > LEN_W'(DATA_W))   len_cfg = LEN_W'(DATA_W);
    end

    // Bit index: 0 = start, 1..len = data, then optional parity, then stop bit(s).
    assign bit_end   = (edge_q == p_q - PRESCALE_W'(1));
    assign stop_last = (bitc_q == BCNT_W'(len_q) + BCNT_W'(1) + BCNT_W'(par_en_q) + BCNT_W'(stop2_q));
    assign stp_now   = stp_flag_q | ~bit_val;
    assign glitch    = (state_q == START) && bit_end && bit_val;

`ifdef UART_RX_BREAK_DET_EN
    assign first_stop = (bitc_q == BCNT_W'(len_q) + BCNT_W'(1) + BCNT_W'(par_en_q));
    assign brk_hit    = (state_q == STOP) && bit_end && first_stop && brk_cand_q && !bit_val;
    assign complete   = (state_q == STOP) && bit_end && stop_last && !brk_hit;
    assign BRK_DET    = brk_hit;
`else
    assign complete   = (state_q == STOP) && bit_end && stop_last;
`endif

    assign frame_ok    = complete && !par_flag_q && !stp_now;
    assign DATA_VALID  = frame_ok;
    assign P_DATA      = frame_ok ? shreg_q : p_data_q;
    assign PAR_ERR     = complete ? par_flag_q : par_err_q;
    assign STP_ERR     = complete ? stp_now : stp_err_q;
    assign STRT_GLITCH = glitch;
    assign BUSY        = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        edge_d      = edge_q;
        bitc_d      = bitc_q;
        p_d         = p_q;
        len_d       = len_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        stop2_d     = stop2_q;
        shreg_d     = shreg_q;
        p_data_d    = p_data_q;
        par_flag_d  = par_flag_q;
        stp_flag_d  = stp_flag_q;
        par_err_d   = par_err_q;
        stp_err_d   = stp_err_q;
        start_frame = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_cand_d  = brk_cand_q;
`endif

        if (state_q != IDLE) begin
            edge_d = bit_end ? '0 : edge_q + PRESCALE_W'(1);
            if (bit_end) bitc_d = bitc_q + BCNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!RX_IN) start_frame = 1'b1;
            end
            START: begin
                if (bit_end) state_d = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    for (int i = 0; i < DATA_W; i++)
                        if (BCNT_W'(i) == bitc_q - BCNT_W'(1)) shreg_d[i] = bit_val;
`ifdef UART_RX_BREAK_DET_EN
                    brk_cand_d = brk_cand_q & ~bit_val;
`endif
                    if (bitc_q == BCNT_W'(len_q)) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    if (bit_val != ((^shreg_q) ^ (par_typ_q == PAR_ODD))) par_flag_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                    brk_cand_d = brk_cand_q & ~bit_val;
`endif
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!bit_val) stp_flag_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                    if (brk_hit) begin
                        state_d = BRK_WAIT;
                        edge_d  = '0;
                    end else
`endif
                    if (stop_last) begin
                        par_err_d = par_flag_q;
                        stp_err_d = stp_now;
                        if (frame_ok) p_data_d = shreg_q;
                        // A low line at the last stop edge is already the next start bit.
                        if (!RX_IN) start_frame = 1'b1;
                        else        state_d     = IDLE;
                    end
                end
            end
            BRK_WAIT: begin
                // edge_cnt here counts consecutive high samples of the released line.
                if (!RX_IN)       edge_d  = '0;
                else if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d    = START;
            edge_d     = '0;
            bitc_d     = '0;
            shreg_d    = '0;
            par_flag_d = 1'b0;
            stp_flag_d = 1'b0;
            p_d        = p_cfg;
            len_d      = len_cfg;
            par_en_d   = PAR_EN;
            par_typ_d  = par_typ_e'(PAR_TYP);
            stop2_d    = STOP2;
`ifdef UART_RX_BREAK_DET_EN
            brk_cand_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bitc_q     <= '0;
            p_q        <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            stop2_q    <= 1'b0;
            shreg_q    <= '0;
            p_data_q   <= '0;
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_cand_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bitc_q     <= bitc_d;
            p_q        <= p_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            shreg_q    <= shreg_d;
            p_data_q   <= p_data_d;
            par_flag_q <= par_flag_d;
            stp_flag_q <= stp_flag_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
`ifdef UART_RX_BREAK_DET_EN
            brk_cand_q <= brk_cand_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are driven bit-by-bit on the falling clock edge
// and outputs are compared against hand-computed values at the same falling edges.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rx  = 1'b1;
    logic [5:0] prescale;
    logic [3:0] data_len;
    logic       par_en, par_typ, stop2;
    logic [7:0] p_data;
    logic       dv, par_err, stp_err, glitch, busy;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk_det;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int dv_cnt = 0;
    int d0;

    uart_rx_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (rx),
        .PRESCALE    (prescale),
        .DATA_LEN    (data_len),
        .PAR_EN      (par_en),
        .PAR_TYP     (par_typ),
        .STOP2       (stop2),
        .P_DATA      (p_data),
        .DATA_VALID  (dv),
        .PAR_ERR     (par_err),
        .STP_ERR     (stp_err),
        .STRT_GLITCH (glitch),
`ifdef UART_RX_BREAK_DET_EN
        .BRK_DET     (brk_det),
`endif
        .BUSY        (busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (dv) dv_cnt <= dv_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        rx = b;
        repeat (p) @(negedge CLK);
    endtask

    // Returns on the falling edge inside edge P-1 of the last stop bit, with RX_IN still at the stop value.
    task automatic send(input int p, input logic [8:0] d, input int nbits, input bit pen,
                        input bit ptyp, input bit s2, input bit par_bad, input bit stop_v);
        logic par;
        par = ptyp;
        drive_bit(1'b0, p);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(d[i], p);
            par ^= d[i];
        end
        if (pen) drive_bit(par ^ par_bad, p);
        drive_bit(stop_v, p);
        if (s2) drive_bit(stop_v, p);
    endtask

    initial begin
        prescale = 6'd8; data_len = 4'd8; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_pdata", p_data, 0);
        check("rst_dv", dv, 0);
        check("rst_par_err", par_err, 0);
        check("rst_stp_err", stp_err, 0);
        check("rst_glitch", glitch, 0);
        check("rst_busy", busy, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // P=8, 8N1, 0xA5
        d0 = dv_cnt;
        send(8, 9'h0A5, 8, 0, 0, 0, 0, 1);
        check("a5_dv", dv, 1);
        check("a5_data", p_data, 8'hA5);
        check("a5_par_err", par_err, 0);
        check("a5_stp_err", stp_err, 0);
        @(negedge CLK);
        check("a5_dv_off", dv, 0);
        check("a5_idle", busy, 0);
        check("a5_dv_count", dv_cnt - d0, 1);

        // P=16, 7 data bits, even parity, two stop bits, 0x5A
        prescale = 6'd16; data_len = 4'd7; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1;
        send(16, 9'h05A, 7, 1, 0, 1, 0, 1);
        check("5a_busy_stop2", busy, 1);
        check("5a_dv", dv, 1);
        check("5a_data", p_data, 8'h5A);
        check("5a_par_err", par_err, 0);
        @(negedge CLK);
        check("5a_idle", busy, 0);

        // P=8, 8O1, 0x0F with bad parity, then a good 0x33
        prescale = 6'd8; data_len = 4'd8; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0;
        d0 = dv_cnt;
        send(8, 9'h00F, 8, 1, 1, 0, 1, 1);
        check("0f_par_err", par_err, 1);
        check("0f_dv", dv, 0);
        check("0f_data_hold", p_data, 8'h5A);
        check("0f_stp_err", stp_err, 0);
        @(negedge CLK);
        check("0f_par_err_hold", par_err, 1);
        check("0f_dv_count", dv_cnt - d0, 0);
        send(8, 9'h033, 8, 1, 1, 0, 0, 1);
        check("33_par_err", par_err, 0);
        check("33_dv", dv, 1);
        check("33_data", p_data, 8'h33);
        @(negedge CLK);

        // P=8 false start: 2 low cycles, pulse expected at edge 7
        par_en = 1'b0; par_typ = 1'b0;
        d0 = dv_cnt;
        rx = 1'b0;
        repeat (2) @(negedge CLK);
        rx = 1'b1;
        repeat (6) @(negedge CLK);
        check("gl_pulse", glitch, 1);
        check("gl_busy", busy, 1);
        @(negedge CLK);
        check("gl_pulse_off", glitch, 0);
        check("gl_idle", busy, 0);
        check("gl_par_err", par_err, 0);
        check("gl_no_dv", dv_cnt - d0, 0);

        // P=32 back-to-back 0x11, 0x22
        prescale = 6'd32;
        d0 = dv_cnt;
        send(32, 9'h011, 8, 0, 0, 0, 0, 1);
        check("b2b1_dv", dv, 1);
        check("b2b1_data", p_data, 8'h11);
        send(32, 9'h022, 8, 0, 0, 0, 0, 1);
        check("b2b2_dv", dv, 1);
        check("b2b2_data", p_data, 8'h22);
        @(negedge CLK);
        check("b2b_dv_count", dv_cnt - d0, 2);

        // Clamping: PRESCALE 9 -> 8, DATA_LEN 15 -> 8; PRESCALE 4 -> 8, DATA_LEN 2 -> 5
        prescale = 6'd9; data_len = 4'd15;
        send(8, 9'h096, 8, 0, 0, 0, 0, 1);
        check("clamp_hi_dv", dv, 1);
        check("clamp_hi_data", p_data, 8'h96);
        @(negedge CLK);
        prescale = 6'd4; data_len = 4'd2;
        send(8, 9'h015, 5, 0, 0, 0, 0, 1);
        check("clamp_lo_dv", dv, 1);
        check("clamp_lo_data", p_data, 8'h15);
        @(negedge CLK);

        // Stop error: 0x81 with a low stop bit
        prescale = 6'd8; data_len = 4'd8;
        send(8, 9'h081, 8, 0, 0, 0, 0, 0);
        check("stp_err", stp_err, 1);
        check("stp_dv", dv, 0);
        check("stp_data_hold", p_data, 8'h15);
        check("stp_par_err", par_err, 0);
        rx = 1'b1;
        @(negedge CLK);
        check("stp_err_hold", stp_err, 1);
        check("stp_idle", busy, 0);

        // Reset in the middle of 0xC3, then 0x3C
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        check("rm_busy", busy, 1);
        RST = 1'b0;
        rx  = 1'b1;
        #1;
        check("rm_pdata", p_data, 0);
        check("rm_busy_off", busy, 0);
        check("rm_stp_err", stp_err, 0);
        check("rm_dv", dv, 0);
        check("rm_par_err", par_err, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        send(8, 9'h03C, 8, 0, 0, 0, 0, 1);
        check("3c_dv", dv, 1);
        check("3c_data", p_data, 8'h3C);
        check("3c_stp_err", stp_err, 0);
        @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
